montgomery_precompute: RTL

Computes the Montgomery constants for a 64-bit odd modulus: the bit length `m_bl` (so R = 2^m_bl > m) and `minv = -m^-1 mod R`. It sits directly upstream of `montgomery_pipelined` and feeds its `m_i`, `m_bl_i` and `minv_i` inputs. Its `valid_o` pulse tells the control logic the constants are stable, so reductions can be started. The inverse is produced by a bit-serial Hensel lifting loop that uses only adds and shifts, with no multiplier.

---
 rtl/montgomery_precompute.sv | 170 +++++++++++++++++
 1 files changed

// File: rtl/montgomery_precompute.sv
// -----------------------------------------------------------------------------
// montgomery_precompute
//
// Derives the Montgomery constants for a 64-bit odd modulus m:
//   m_bl = bit length of m (so R = 2^m_bl > m)
//   minv = -m^-1 mod R
// The inverse is built bit-serially by Hensel lifting (adds and shifts only),
// so latency is fixed at 66 cycles from accept to valid. An even or zero
// modulus is flagged as an error after 2 cycles.
//
// Ports:
//   clk_i    in   1   rising-edge clock
//   rst_i    in   1   synchronous active-high reset
//   start_i  in   1   request, sampled only while idle
//   m_i      in  64   modulus, captured on the accepted start
//   busy_o   out  1   high from the cycle after accept through the valid cycle
//   valid_o  out  1   one-cycle pulse, outputs below valid from this cycle on
//   error_o  out  1   modulus was even or zero
//   m_o      out 64   captured modulus
//   m_bl_o   out 64   bit length of m, zero-extended
//   minv_o   out 64   -m^-1 mod 2^m_bl (zero on error)
// -----------------------------------------------------------------------------
module montgomery_precompute (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        start_i,
    input  logic [63:0] m_i,
    output logic        busy_o,
    output logic        valid_o,
    output logic        error_o,
    output logic [63:0] m_o,
    output logic [63:0] m_bl_o,
    output logic [63:0] minv_o
);

    localparam int DATA_W = 64;

    typedef enum logic [2:0] {
        S_IDLE,
        S_BITLEN,
        S_INVERT,
        S_FINAL,
        S_DONE
    } state_t;

    state_t              r_state;
    logic [DATA_W-1:0]   r_m_q;
    logic [DATA_W-1:0]   r_y;      // partial inverse of m
    logic [DATA_W-1:0]   r_t;      // m * r_y mod 2^64
    logic [5:0]          r_i;
    logic [6:0]          r_bl;

    logic                r_busy;
    logic                r_valid;
    logic                r_error;
    logic [DATA_W-1:0]   r_m;
    logic [DATA_W-1:0]   r_m_bl;
    logic [DATA_W-1:0]   r_minv;

    logic [6:0]          w_bl;
    logic [DATA_W-1:0]   w_minv;
    logic [DATA_W-1:0]   w_addend;

    // Index of the highest set bit plus one; 0 when no bit is set.
    function automatic logic [6:0] bit_length(input logic [DATA_W-1:0] v);
        logic [6:0] n;
        n = '0;
        for (int k = 0; k < DATA_W; k++) begin
            if (v[k]) n = 7'(k + 1);
        end
        return n;
    endfunction

    // Low bl bits set. bl = 64 is special-cased so the shift cannot wrap.
    function automatic logic [DATA_W-1:0] low_mask(input logic [6:0] bl);
        if (bl >= 7'd64) return '1;
        return (64'd1 << bl) - 64'd1;
    endfunction

    // Two's-complement negate, reduced modulo 2^bl by masking.
    function automatic logic [DATA_W-1:0] neg_mod(input logic [DATA_W-1:0] y,
                                                  input logic [6:0]        bl);
        return (~y + 64'd1) & low_mask(bl);
    endfunction

    assign w_bl     = bit_length(r_m_q);
    assign w_minv   = neg_mod(r_y, r_bl);
    assign w_addend = r_m_q << r_i;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            // Datapath registers are left alone; they are reloaded on accept.
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
            r_valid <= 1'b0;
            r_error <= 1'b0;
            r_m     <= '0;
            r_m_bl  <= '0;
            r_minv  <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start_i) begin
                        r_m_q   <= m_i;
                        r_y     <= 64'd1;
                        r_t     <= m_i;
                        r_i     <= 6'd1;
                        r_busy  <= 1'b1;
                        r_state <= S_BITLEN;
                    end
                end

                S_BITLEN: begin
                    r_bl <= w_bl;
                    if (!r_m_q[0]) begin
                        // Even or zero modulus has no inverse: publish error now.
                        r_m     <= r_m_q;
                        r_m_bl  <= {57'd0, w_bl};
                        r_minv  <= '0;
                        r_error <= 1'b1;
                        r_valid <= 1'b1;
                        r_state <= S_DONE;
                    end else begin
                        r_state <= S_INVERT;
                    end
                end

                S_INVERT: begin
                    // Invariant: m*y == 1 mod 2^i on entry. If bit i of m*y is
                    // set, adding 2^i to y (i.e. m<<i to t) clears it.
                    if (r_t[r_i]) begin
                        r_y[r_i] <= 1'b1;
                        r_t      <= r_t + w_addend;
                    end
                    r_i <= r_i + 6'd1;
                    if (r_i == 6'd63) r_state <= S_FINAL;
                end

                S_FINAL: begin
                    r_m     <= r_m_q;
                    r_m_bl  <= {57'd0, r_bl};
                    r_minv  <= w_minv;
                    r_error <= 1'b0;
                    r_valid <= 1'b1;
                    r_state <= S_DONE;
                end

                S_DONE: begin
                    r_valid <= 1'b0;
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end

                default: begin
                    r_valid <= 1'b0;
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign busy_o  = r_busy;
    assign valid_o = r_valid;
    assign error_o = r_error;
    assign m_o     = r_m;
    assign m_bl_o  = r_m_bl;
    assign minv_o  = r_minv;

endmodule
